keypad_scan_debounce: RTL and testbench

KEYPAD_SCAN_DEBOUNCE -- requirements
Module: keypad_scan_debounce

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_sync2.sv | 26 ++
 rtl/keypad_scan_debounce.sv | 202 ++++++++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM encoding, default timing
// constants and the row/column to key-code table.
package keypad_pkg;

  localparam int DEF_SCAN_DIV     = 5000;
  localparam int DEF_DEBOUNCE_CNT = 4;

  typedef enum logic [1:0] {
    ST_SCAN      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_HELD      = 2'd2,
    ST_DEB_REL   = 2'd3
  } state_e;

  // Indexed by {row, col}; entry 0 is row 0 / column 0.
  localparam logic [15:0][3:0] KEY_TABLE = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return KEY_TABLE[{r, c}];
  endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for the asynchronous keypad rows; resets to the
// idle (all released) level so no phantom press follows reset.
module keypad_sync2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_r;
  logic [3:0] sync_r;

  // Two-stage capture of the raw row levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= 4'b1111;
      sync_r <= 4'b1111;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad column scanner with press/release debouncing. One row sample
// is taken per column slot; all decisions happen on that sample cycle.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] column,
  output logic [3:0] keypad_data,
  output logic       key_valid,
  output logic       interrupt
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);

  logic [3:0]        row_sync_s;
  logic [3:0]        rows_low_s;
  logic              one_low_s;
  logic [1:0]        row_idx_s;
  logic              match_s;
  logic              cand_low_s;
  logic              all_high_s;
  logic              sample_s;
  logic [SLOT_W-1:0] slot_cnt_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [1:0]        col_idx_r;
  logic [1:0]        cand_row_r;
  logic [1:0]        cand_col_r;
  logic [3:0]        column_r;
  logic [3:0]        keypad_data_r;
  logic              key_valid_r;
  logic              interrupt_r;
  logic              rotate_s;
  logic              load_cand_s;
  logic              confirm_s;
  logic              release_s;
  state_e            state_r;
  state_e            state_nxt_s;

  keypad_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row),
    .q     (row_sync_s)
  );

  assign sample_s = (slot_cnt_r == SLOT_LAST);

  // Classify the synchronized rows: single low row, its index, release level.
  always_comb begin
    rows_low_s = ~row_sync_s;
    one_low_s  = (rows_low_s != 4'b0000) && ((rows_low_s & (rows_low_s - 4'd1)) == 4'b0000);
    case (rows_low_s)
      4'b0001: row_idx_s = 2'd0;
      4'b0010: row_idx_s = 2'd1;
      4'b0100: row_idx_s = 2'd2;
      4'b1000: row_idx_s = 2'd3;
      default: row_idx_s = 2'd0;
    endcase
    match_s    = one_low_s && (row_idx_s == cand_row_r);
    cand_low_s = ~row_sync_s[cand_row_r];
    all_high_s = (row_sync_s == 4'b1111);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_SCAN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decision, evaluated only on the sample cycle.
  always_comb begin
    state_nxt_s = state_r;
    if (sample_s) begin
      case (state_r)
        ST_SCAN: begin
          if (one_low_s) state_nxt_s = ST_DEB_PRESS;
          else           state_nxt_s = ST_SCAN;
        end
        ST_DEB_PRESS: begin
          if (!match_s)              state_nxt_s = ST_SCAN;
          else if (cnt_r == CNT_LAST) state_nxt_s = ST_HELD;
          else                       state_nxt_s = ST_DEB_PRESS;
        end
        ST_HELD: begin
          if (!cand_low_s) state_nxt_s = ST_DEB_REL;
          else             state_nxt_s = ST_HELD;
        end
        ST_DEB_REL: begin
          if (all_high_s && (cnt_r == CNT_LAST)) state_nxt_s = ST_SCAN;
          else if (cand_low_s)                   state_nxt_s = ST_HELD;
          else                                   state_nxt_s = ST_DEB_REL;
        end
        default: state_nxt_s = ST_SCAN;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Datapath controls and debounce count for the current sample.
  always_comb begin
    rotate_s    = 1'b0;
    load_cand_s = 1'b0;
    confirm_s   = 1'b0;
    release_s   = 1'b0;
    cnt_nxt_s   = cnt_r;
    if (sample_s) begin
      case (state_r)
        ST_SCAN: begin
          if (one_low_s) begin
            load_cand_s = 1'b1;
            cnt_nxt_s   = CNT_ONE;
          end else begin
            rotate_s  = 1'b1;
            cnt_nxt_s = CNT_ZERO;
          end
        end
        ST_DEB_PRESS: begin
          if (!match_s) begin
            rotate_s  = 1'b1;
            cnt_nxt_s = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            confirm_s = 1'b1;
            cnt_nxt_s = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_HELD: begin
          if (!cand_low_s) cnt_nxt_s = CNT_ONE;
          else             cnt_nxt_s = CNT_ZERO;
        end
        ST_DEB_REL: begin
          if (all_high_s && (cnt_r == CNT_LAST)) begin
            release_s = 1'b1;
            rotate_s  = 1'b1;
            cnt_nxt_s = CNT_ZERO;
          end else if (all_high_s) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end else if (cand_low_s) begin
            cnt_nxt_s = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        default: cnt_nxt_s = CNT_ZERO;
      endcase
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Slot timer, column drive, candidate capture and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_r    <= '0;
      cnt_r         <= '0;
      col_idx_r     <= 2'd0;
      column_r      <= 4'b1110;
      cand_row_r    <= 2'd0;
      cand_col_r    <= 2'd0;
      keypad_data_r <= 4'h0;
      key_valid_r   <= 1'b0;
      interrupt_r   <= 1'b0;
    end else begin
      slot_cnt_r <= sample_s ? '0 : slot_cnt_r + 1'b1;
      cnt_r      <= cnt_nxt_s;
      if (rotate_s) begin
        col_idx_r <= col_idx_r + 2'd1;
        column_r  <= {column_r[2:0], column_r[3]};
      end
      if (load_cand_s) begin
        cand_row_r <= row_idx_s;
        cand_col_r <= col_idx_r;
      end
      if (confirm_s) keypad_data_r <= key_code(cand_row_r, cand_col_r);
      if (confirm_s)      key_valid_r <= 1'b1;
      else if (release_s) key_valid_r <= 1'b0;
      interrupt_r <= confirm_s;
    end
  end

  assign column      = column_r;
  assign keypad_data = keypad_data_r;
  assign key_valid   = key_valid_r;
  assign interrupt   = interrupt_r;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Scoreboarded bench: each intended press queues its key code, and every
// interrupt pulse pops and compares against the queue.
module tb_keypad_scan_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] column;
  logic [3:0] keypad_data;
  logic       key_valid;
  logic       interrupt;

  logic       key_on;
  logic [1:0] key_r;
  logic [1:0] key_c;
  logic       force_en;
  logic [3:0] force_val;

  int         checks_cnt = 0;
  int         errors_cnt = 0;
  int         irq_cnt    = 0;
  logic [3:0] exp_q[$];

  keypad_scan_debounce #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .row         (row),
    .column      (column),
    .keypad_data (keypad_data),
    .key_valid   (key_valid),
    .interrupt   (interrupt)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low only while its column is driven.
  assign row = force_en ? force_val :
               ((key_on && column[key_c] == 1'b0) ? ~(4'b0001 << key_r) : 4'b1111);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && interrupt) begin
      irq_cnt++;
      if (exp_q.size() == 0) check("unexpected_irq", 32'd1, 32'd0);
      else                   check("irq_data", {28'd0, keypad_data}, {28'd0, exp_q.pop_front()});
    end
  end

  task automatic wait_kv(input logic lvl, input int max_cycles, input string tag, output int n);
    n = 0;
    while (key_valid !== lvl && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, key_valid}, {31'd0, lvl});
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    key_r  = r;
    key_c  = c;
    key_on = 1'b1;
  endtask

  initial begin
    int n;
    int base;
    int changes;
    logic [3:0] prev;
    logic kv_min;

    reset = 1'b1; key_on = 1'b0; key_r = 2'd0; key_c = 2'd0;
    force_en = 1'b0; force_val = 4'b1111;
    repeat (3) @(negedge clk);
    check("rst_column", {28'd0, column}, 32'he);
    check("rst_data", {28'd0, keypad_data}, 32'h0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_irq", {31'd0, interrupt}, 32'd0);
    reset = 1'b0;

    // Idle rotation, one step per slot.
    prev = column;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (column == prev && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("col_rot", {28'd0, column}, {28'd0, prev[2:0], prev[3]});
      prev = column;
    end

    // Key '6': row 1, column 2.
    base = irq_cnt;
    exp_q.push_back(4'h6);
    press(2'd1, 2'd2);
    wait_kv(1'b1, 200, "k6_valid", n);
    check("k6_data", {28'd0, keypad_data}, 32'h6);
    repeat (8) @(negedge clk);
    key_on = 1'b0;
    wait_kv(1'b0, 100, "k6_release", n);
    check("k6_irq_cnt", irq_cnt - base, 32'd1);

    // Bouncing key '8' (row 2, column 1): no confirmation while it toggles.
    base = irq_cnt;
    press(2'd2, 2'd1);
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      key_on = ~key_on;
    end
    check("bounce_no_irq", irq_cnt - base, 32'd0);
    exp_q.push_back(4'h8);
    key_on = 1'b1;
    wait_kv(1'b1, 200, "bounce_valid", n);
    key_on = 1'b0;
    wait_kv(1'b0, 100, "bounce_release", n);
    check("bounce_irq_cnt", irq_cnt - base, 32'd1);

    // Two rows low together is never a key, and scanning continues.
    base = irq_cnt;
    force_en = 1'b1; force_val = 4'b1100;
    changes = 0;
    prev = column;
    repeat (40) begin
      @(negedge clk);
      if (column != prev) changes++;
      prev = column;
    end
    force_en = 1'b0;
    check("multi_rotates", {31'd0, changes >= 9}, 32'd1);
    check("multi_no_irq", irq_cnt - base, 32'd0);
    check("multi_no_valid", {31'd0, key_valid}, 32'd0);

    // Long hold of '*' (row 3, column 0), then release latency of three samples.
    base = irq_cnt;
    exp_q.push_back(4'hE);
    press(2'd3, 2'd0);
    wait_kv(1'b1, 200, "star_valid", n);
    repeat (200) @(negedge clk);
    check("star_held", {31'd0, key_valid}, 32'd1);
    check("star_data", {28'd0, keypad_data}, 32'he);
    key_on = 1'b0;
    wait_kv(1'b0, 40, "star_release", n);
    check("star_rel_latency", {31'd0, (n >= 11) && (n <= 14)}, 32'd1);
    check("star_data_kept", {28'd0, keypad_data}, 32'he);
    check("star_irq_cnt", irq_cnt - base, 32'd1);

    // Reset while debouncing a press of '1' (second matching sample taken).
    base = irq_cnt;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    press(2'd0, 2'd0);
    repeat (10) @(negedge clk);
    check("pre_rst_valid", {31'd0, key_valid}, 32'd0);
    reset = 1'b1;
    key_on = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_column", {28'd0, column}, 32'he);
    check("mid_rst_data", {28'd0, keypad_data}, 32'h0);
    check("mid_rst_valid", {31'd0, key_valid}, 32'd0);
    check("mid_rst_irq", {31'd0, interrupt}, 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_rst_no_irq", irq_cnt - base, 32'd0);
    check("mid_rst_no_valid", {31'd0, key_valid}, 32'd0);

    // Release glitch on 'C' (row 2, column 3): one high sample, then held again.
    base = irq_cnt;
    exp_q.push_back(4'hC);
    press(2'd2, 2'd3);
    wait_kv(1'b1, 200, "glitch_valid", n);
    repeat (6) @(negedge clk);
    key_on = 1'b0;
    kv_min = 1'b1;
    repeat (4) begin
      @(negedge clk);
      kv_min = kv_min & key_valid;
    end
    key_on = 1'b1;
    repeat (40) begin
      @(negedge clk);
      kv_min = kv_min & key_valid;
    end
    check("glitch_valid_kept", {31'd0, kv_min}, 32'd1);
    check("glitch_irq_cnt", irq_cnt - base, 32'd1);
    key_on = 1'b0;
    wait_kv(1'b0, 100, "glitch_release", n);

    repeat (10) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule
